// File: rtl/bf2i_stage_ctrl.sv
// Handshake and frame-tracking controller for one radix-2 butterfly stage.
// The butterfly output register acts as a one-entry buffer; sideband markers travel with it.
module bf2i_stage_ctrl #(
   parameter int BLOCKS_PER_FRAME = 32,
   parameter int CNT_W            = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             bf_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sof,
   output logic             out_eof,
   output logic [CNT_W-1:0] out_blk_idx,
   input  logic             flush,
   output logic             busy,
   output logic             err_pulse,
   output logic [7:0]       err_cnt
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCKS_PER_FRAME - 1);

   st_t              st, st_next;
   logic [CNT_W-1:0] blk_cnt, blk_cnt_next;
   logic             accept;
   logic             at_last;
   logic             eof_cond;
   logic             mismatch;

   assign in_ready = !flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign bf_en    = accept;
   assign at_last  = (blk_cnt == LAST_IDX);
   assign eof_cond = at_last || in_last;
   // Early last or missing last; the frame closes at this block either way.
   assign mismatch = (in_last && !at_last) || (at_last && !in_last);
   assign busy     = (st == RUN) || out_valid;

   always_comb begin
      st_next      = st;
      blk_cnt_next = blk_cnt;
      if (flush) begin
         st_next      = IDLE;
         blk_cnt_next = '0;
      end else if (accept) begin
         st_next      = eof_cond ? IDLE : RUN;
         blk_cnt_next = eof_cond ? '0 : blk_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         blk_cnt     <= '0;
         out_valid   <= 1'b0;
         out_sof     <= 1'b0;
         out_eof     <= 1'b0;
         out_blk_idx <= '0;
         err_pulse   <= 1'b0;
         err_cnt     <= '0;
      end else begin
         st        <= st_next;
         blk_cnt   <= blk_cnt_next;
         err_pulse <= accept && mismatch;
         if (flush)
            out_valid <= 1'b0;
         else if (accept)
            out_valid <= 1'b1;
         else if (out_ready)
            out_valid <= 1'b0;
         // Sideband loads in the same cycle the butterfly captures its data.
         if (accept) begin
            out_blk_idx <= blk_cnt;
            out_sof     <= (blk_cnt == '0);
            out_eof     <= eof_cond;
            if (mismatch && err_cnt != 8'hFF)
               err_cnt <= err_cnt + 8'd1;
         end
      end
   end

endmodule
